adder_result_checker: RTL and testbench

- Synthesizable self-checking monitor for the 8-bit ripple-carry adder; it sits on the far side of the adder from the stimulus source.
- Each valid beat delivers the operands (a, b, cin) and the adder's response (sum, cout). The block recomputes the golden result, compares, and keeps pass/error tallies.
- It records the first failing vector for debug.
- Used in board-level and simulation regressions; after a run it reports a single pass/fail verdict.

---
 rtl/adder_result_checker_pkg.sv | 16 +
 rtl/adder_result_checker_golden_add.sv | 19 +
 rtl/adder_result_checker.sv | 170 +++++++++++++++++
 tb/tb_adder_result_checker.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/adder_result_checker_pkg.sv
// Shared definitions for the adder result checker: default widths and the
// run-control state encoding.
package adder_result_checker_pkg;

  localparam int unsigned WIDTH_DEF = 8;   // operand/sum width
  localparam int unsigned CNT_W_DEF = 16;  // check/error counter width

  // Run-control states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/adder_result_checker_golden_add.sv
// golden_add: combinational reference adder, WIDTH+1-bit result so the
// carry-out is never truncated.
// Ports: i_a, i_b (operands), i_cin (carry-in), o_sum_c ({carry, sum}).
module golden_add #(
  parameter int unsigned WIDTH = adder_result_checker_pkg::WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  output logic [WIDTH:0]   o_sum_c
);

  localparam int unsigned SUM_W = WIDTH + 1;

  always_comb begin
    o_sum_c = {1'b0, i_a} + {1'b0, i_b} + SUM_W'(i_cin);
  end

endmodule

// File: rtl/adder_result_checker.sv
// adder_result_checker: monitors an adder's responses, recomputes the golden
// result one cycle after each accepted beat and keeps saturating pass/error
// tallies plus the operands of the first failing vector.
// Ports:
//   clk, rst            - clock, async active-high reset
//   start               - pulse that begins a run (from IDLE or DONE)
//   in_valid, last      - beat qualifier, final-beat marker
//   a, b, cin, sum, cout - operands and adder response for the beat
//   busy, done, pass    - run status / verdict
//   chk_count, err_count - beats compared / mismatches this run
//   first_err_*         - capture of the first mismatching vector
module adder_result_checker #(
  parameter int unsigned WIDTH = adder_result_checker_pkg::WIDTH_DEF,
  parameter int unsigned CNT_W = adder_result_checker_pkg::CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic [WIDTH-1:0] sum,
  input  logic             cout,
  input  logic             last,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [CNT_W-1:0] chk_count,
  output logic [CNT_W-1:0] err_count,
  output logic             first_err_valid,
  output logic [WIDTH-1:0] first_err_a,
  output logic [WIDTH-1:0] first_err_b,
  output logic             first_err_cin
);

  import adder_result_checker_pkg::*;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           r_state;
  state_t           w_state_nxt;

  logic             r_s1_valid;
  logic [WIDTH-1:0] r_s1_a;
  logic [WIDTH-1:0] r_s1_b;
  logic             r_s1_cin;
  logic [WIDTH-1:0] r_s1_sum;
  logic             r_s1_cout;

  logic [CNT_W-1:0] r_chk_count;
  logic [CNT_W-1:0] r_err_count;
  logic             r_fe_valid;
  logic [WIDTH-1:0] r_fe_a;
  logic [WIDTH-1:0] r_fe_b;
  logic             r_fe_cin;

  logic [WIDTH:0]   w_expected;
  logic             w_accept;
  logic             w_clear;
  logic             w_mismatch;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:  if (start) w_state_nxt = ST_RUN;
      ST_RUN:   if (in_valid && last) w_state_nxt = ST_DRAIN;
      ST_DRAIN: w_state_nxt = ST_DONE;
      ST_DONE:  if (start) w_state_nxt = ST_RUN;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  // Status outputs decoded from the state register
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    pass = 1'b0;
    case (r_state)
      ST_RUN:  busy = 1'b1;
      ST_DONE: begin
        done = 1'b1;
        pass = (r_err_count == '0);
      end
      default: ;
    endcase
  end

  assign w_accept = (r_state == ST_RUN) && in_valid;
  assign w_clear  = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));

  // Stage 1: register the accepted beat
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_valid <= 1'b0;
      r_s1_a     <= '0;
      r_s1_b     <= '0;
      r_s1_cin   <= 1'b0;
      r_s1_sum   <= '0;
      r_s1_cout  <= 1'b0;
    end else begin
      r_s1_valid <= w_accept;
      if (w_accept) begin
        r_s1_a    <= a;
        r_s1_b    <= b;
        r_s1_cin  <= cin;
        r_s1_sum  <= sum;
        r_s1_cout <= cout;
      end
    end
  end

  golden_add #(.WIDTH(WIDTH)) u_golden_add (
    .i_a     (r_s1_a),
    .i_b     (r_s1_b),
    .i_cin   (r_s1_cin),
    .o_sum_c (w_expected)
  );

  // Carry and sum are both part of the compare
  assign w_mismatch = r_s1_valid && ({r_s1_cout, r_s1_sum} != w_expected);

  // Stage 2: saturating tallies and first-error capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_chk_count <= '0;
      r_err_count <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_a      <= '0;
      r_fe_b      <= '0;
      r_fe_cin    <= 1'b0;
    end else if (w_clear) begin
      r_chk_count <= '0;
      r_err_count <= '0;
      r_fe_valid  <= 1'b0;
      r_fe_a      <= '0;
      r_fe_b      <= '0;
      r_fe_cin    <= 1'b0;
    end else if (r_s1_valid) begin
      if (r_chk_count != CNT_MAX) r_chk_count <= r_chk_count + CNT_W'(1);
      if (w_mismatch) begin
        if (r_err_count != CNT_MAX) r_err_count <= r_err_count + CNT_W'(1);
        if (!r_fe_valid) begin
          r_fe_valid <= 1'b1;
          r_fe_a     <= r_s1_a;
          r_fe_b     <= r_s1_b;
          r_fe_cin   <= r_s1_cin;
        end
      end
    end
  end

  assign chk_count       = r_chk_count;
  assign err_count       = r_err_count;
  assign first_err_valid = r_fe_valid;
  assign first_err_a     = r_fe_a;
  assign first_err_b     = r_fe_b;
  assign first_err_cin   = r_fe_cin;

endmodule

// File: tb/tb_adder_result_checker.sv
// Directed bench for adder_result_checker. Two instances (16-bit and 4-bit
// counters) see the same stimulus; a spec-level model predicts outputs that
// are compared every falling edge, plus literal checks at run ends.
module tb_adder_result_checker;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a = '0;
  logic [7:0] b = '0;
  logic       cin = 1'b0;
  logic [7:0] sum = '0;
  logic       cout = 1'b0;
  logic       last = 1'b0;

  logic        busy16, done16, pass16, fev16, fc16;
  logic [15:0] chk16, err16;
  logic [7:0]  fa16, fb16;
  logic        busy4, done4, pass4, fev4, fc4;
  logic [3:0]  chk4, err4;
  logic [7:0]  fa4, fb4;

  int n_vec = 0;
  int n_bad = 0;

  // Model state: run phase, unbounded tallies, pending beat
  int       m_mode = 0;   // 0 idle, 1 running, 2 draining, 3 finished
  int       m_chk = 0;
  int       m_err = 0;
  bit       m_fev = 0;
  int       m_fa = 0, m_fb = 0, m_fc = 0;
  bit       p_v = 0;
  int       p_a, p_b, p_c, p_s, p_co;

  always #5 clk = ~clk;

  adder_result_checker #(.WIDTH(8), .CNT_W(16)) u_dut (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout), .last(last),
    .busy(busy16), .done(done16), .pass(pass16),
    .chk_count(chk16), .err_count(err16),
    .first_err_valid(fev16), .first_err_a(fa16), .first_err_b(fb16),
    .first_err_cin(fc16)
  );

  adder_result_checker #(.WIDTH(8), .CNT_W(4)) u_dut4 (
    .clk(clk), .rst(rst), .start(start), .in_valid(in_valid),
    .a(a), .b(b), .cin(cin), .sum(sum), .cout(cout), .last(last),
    .busy(busy4), .done(done4), .pass(pass4),
    .chk_count(chk4), .err_count(err4),
    .first_err_valid(fev4), .first_err_a(fa4), .first_err_b(fb4),
    .first_err_cin(fc4)
  );

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (v > mx) ? mx : v;
  endfunction

  task automatic model_reset();
    m_mode = 0; m_chk = 0; m_err = 0;
    m_fev = 0; m_fa = 0; m_fb = 0; m_fc = 0;
    p_v = 0;
  endtask

  // Model of one rising edge, from the inputs held across it
  task automatic model_edge();
    bit n_v;
    int n_a, n_b, n_c, n_s, n_co;
    n_v = 0; n_a = 0; n_b = 0; n_c = 0; n_s = 0; n_co = 0;
    if (m_mode == 1 && in_valid) begin
      n_v = 1; n_a = int'(a); n_b = int'(b); n_c = int'(cin);
      n_s = int'(sum); n_co = int'(cout);
    end
    if (p_v) begin
      m_chk++;
      if (p_a + p_b + p_c != p_co * 256 + p_s) begin
        m_err++;
        if (!m_fev) begin
          m_fev = 1; m_fa = p_a; m_fb = p_b; m_fc = p_c;
        end
      end
    end
    case (m_mode)
      0, 3: if (start) begin
        model_reset();
        m_mode = 1;
      end
      1: if (in_valid && last) m_mode = 2;
      2: m_mode = 3;
      default: m_mode = 0;
    endcase
    p_v = n_v; p_a = n_a; p_b = n_b; p_c = n_c; p_s = n_s; p_co = n_co;
  endtask

  // Continuous compare against the model
  always @(negedge clk) begin
    cmp("busy16", 32'(busy16), 32'(m_mode == 1));
    cmp("done16", 32'(done16), 32'(m_mode == 3));
    cmp("pass16", 32'(pass16), 32'(m_mode == 3 && m_err == 0));
    cmp("chk16", 32'(chk16), 32'(sat(m_chk, 16)));
    cmp("err16", 32'(err16), 32'(sat(m_err, 16)));
    cmp("fev16", 32'(fev16), 32'(m_fev));
    cmp("fa16", 32'(fa16), 32'(m_fa));
    cmp("fb16", 32'(fb16), 32'(m_fb));
    cmp("fc16", 32'(fc16), 32'(m_fc));
    cmp("pass4", 32'(pass4), 32'(m_mode == 3 && m_err == 0));
    cmp("chk4", 32'(chk4), 32'(sat(m_chk, 4)));
    cmp("err4", 32'(err4), 32'(sat(m_err, 4)));
    cmp("fev4", 32'(fev4), 32'(m_fev));
  end

  task automatic step(input bit st, input bit iv, input bit lst,
                      input int av, input int bv, input int cv,
                      input int sv, input int cov);
    start = st; in_valid = iv; last = lst;
    a = 8'(av); b = 8'(bv); cin = 1'(cv); sum = 8'(sv); cout = 1'(cov);
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    step(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic good_beat(input int av, input int bv, input int cv, input bit lst);
    int s;
    s = av + bv + cv;
    step(0, 1, lst, av, bv, cv, s % 256, s / 256);
  endtask

  task automatic finish_run();
    idle();
    idle();
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    cmp("rst_chk", 32'(chk16), 32'd0);
    cmp("rst_busy", 32'(busy16), 32'd0);

    // 1: 256 correct beats
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 256; i++) good_beat(i, i >> 1, i & 1, i == 255);
    finish_run();
    cmp("t1_done", 32'(done16), 32'd1);
    cmp("t1_pass", 32'(pass16), 32'd1);
    cmp("t1_chk", 32'(chk16), 32'd256);
    cmp("t1_err", 32'(err16), 32'd0);
    cmp("t1_fev", 32'(fev16), 32'd0);
    cmp("t1_chk4", 32'(chk4), 32'd15);
    cmp("t1_model", 32'(m_chk), 32'd256);

    // 2: sum corrupted on beat 5, cout flipped on beat 9
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 12; i++) begin
      if (i == 5) step(0, 1, 0, 5, 2, 1, 8'h09, 0);
      else if (i == 9) step(0, 1, 0, 9, 4, 1, 14, 1);
      else good_beat(i, i >> 1, i & 1, i == 11);
    end
    finish_run();
    cmp("t2_err", 32'(err16), 32'd2);
    cmp("t2_chk", 32'(chk16), 32'd12);
    cmp("t2_pass", 32'(pass16), 32'd0);
    cmp("t2_fa", 32'(fa16), 32'h05);
    cmp("t2_fb", 32'(fb16), 32'h02);
    cmp("t2_fc", 32'(fc16), 32'd1);
    cmp("t2_model_err", 32'(m_err), 32'd2);

    // 5: restart from a failing DONE, with a stray last while idle-valid
    step(1, 0, 0, 0, 0, 0, 0, 0);
    cmp("t5_clr_chk", 32'(chk16), 32'd0);
    cmp("t5_clr_fev", 32'(fev16), 32'd0);
    good_beat(8'h10, 8'h20, 0, 0);
    step(0, 0, 1, 0, 0, 0, 0, 0);
    cmp("t5_last_noval", 32'(busy16), 32'd1);
    good_beat(8'h80, 8'h80, 0, 0);
    good_beat(8'h7F, 8'h00, 1, 1);
    finish_run();
    cmp("t5_chk", 32'(chk16), 32'd3);
    cmp("t5_pass", 32'(pass16), 32'd1);

    // 3: single-beat boundary runs
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 8'hFF, 8'hFF, 1, 8'hFF, 1);
    finish_run();
    cmp("t3_chk", 32'(chk16), 32'd1);
    cmp("t3_pass", 32'(pass16), 32'd1);
    step(1, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 8'hFF, 8'hFF, 1, 8'hFF, 0);
    finish_run();
    cmp("t3b_err", 32'(err16), 32'd1);
    cmp("t3b_pass", 32'(pass16), 32'd0);
    cmp("t3b_fa", 32'(fa16), 32'hFF);

    // 6: 20 mismatching beats saturate the 4-bit counters
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 20; i++) step(0, 1, i == 19, i, 0, 0, i + 1, 0);
    finish_run();
    cmp("t6_err4", 32'(err4), 32'd15);
    cmp("t6_chk4", 32'(chk4), 32'd15);
    cmp("t6_pass4", 32'(pass4), 32'd0);
    cmp("t6_err16", 32'(err16), 32'd20);

    // 4: async reset mid-run, then beats without start are ignored
    step(1, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) good_beat(i, 3, 0, 0);
    rst = 1'b1;
    #1;
    cmp("t4_busy", 32'(busy16), 32'd0);
    cmp("t4_chk", 32'(chk16), 32'd0);
    cmp("t4_done", 32'(done16), 32'd0);
    cmp("t4_fev", 32'(fev16), 32'd0);
    model_reset();
    #1 rst = 1'b0;
    for (int i = 0; i < 5; i++) good_beat(i, i, 1, i == 4);
    idle();
    cmp("t4_ign_chk", 32'(chk16), 32'd0);
    cmp("t4_ign_busy", 32'(busy16), 32'd0);
    cmp("t4_ign_done", 32'(done16), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
